// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter sharing one register-bank write port
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int GW    = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]       ack,
    output logic                  wr_err,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     last_q, last_d;
    logic [GW-1:0]     id_q, id_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  bank_q [DEPTH];
    logic [WIDTH-1:0]  bank_d [DEPTH];
    logic [GW-1:0]     winner;
    logic              found;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NREQ;
        return GW'(s);
    endfunction

    // Search begins one past the last served requester so every requester is reached in turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[rr_idx(last_q, k)]) begin
                winner = rr_idx(last_q, k);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ack_d   = '0;
        err_d   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bank_d[i] = bank_q[i];
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = winner;
                    grant_d = winner;
                    addr_d  = wr_addr[winner*AW +: AW];
                    data_d  = wr_data[winner*WIDTH +: WIDTH];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The holding registers, not the live inputs, define the committed write.
                if (int'(addr_q) >= DEPTH) begin
                    err_d = 1'b1;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (AW'(i) == addr_q) begin
                        bank_d[i] = data_q;
                    end
                end
                ack_d[id_q] = 1'b1;
                last_d      = id_q;
                state_d     = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= GW'(NREQ - 1);
            id_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (AW'(i) == rd_addr) begin
                rd_data = bank_q[i];
            end
        end
    end

    assign ack      = ack_q;
    assign wr_err   = err_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - bench for dff_bank_arbiter, full-depth and short-depth instances
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int GW    = 2;
    localparam int WIDTH = 8;
    localparam int AW    = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [AW-1:0]         rd_addr;

    logic [NREQ-1:0]  ack_a, ack_b;
    logic             err_a, err_b;
    logic [GW-1:0]    gnt_a, gnt_b;
    logic             busy_a, busy_b;
    logic [WIDTH-1:0] rd_a, rd_b;

    dff_bank_arbiter #(.NREQ(NREQ), .GW(GW), .WIDTH(WIDTH), .DEPTH(4), .AW(AW)) u_dut_a (
        .clk(clk), .reset(reset), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .ack(ack_a), .wr_err(err_a), .grant_id(gnt_a), .busy(busy_a),
        .rd_addr(rd_addr), .rd_data(rd_a)
    );

    dff_bank_arbiter #(.NREQ(NREQ), .GW(GW), .WIDTH(WIDTH), .DEPTH(3), .AW(AW)) u_dut_b (
        .clk(clk), .reset(reset), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .ack(ack_b), .wr_err(err_b), .grant_id(gnt_b), .busy(busy_b),
        .rd_addr(rd_addr), .rd_data(rd_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference: age -1 = no transaction, 0 = captured, 1 = acknowledged.
    int               age;
    int               m_last, m_id, m_addr;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] bank4 [4];
    logic [WIDTH-1:0] bank3 [3];
    logic [NREQ-1:0]  exp_ack;
    logic             exp_err4, exp_err3, exp_busy;
    int               exp_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        age = -1; m_last = NREQ - 1; m_id = 0; m_addr = 0; m_data = '0;
        for (int i = 0; i < 4; i++) bank4[i] = '0;
        for (int i = 0; i < 3; i++) bank3[i] = '0;
        exp_ack = '0; exp_err4 = 1'b0; exp_err3 = 1'b0; exp_busy = 1'b0; exp_grant = 0;
    endtask

    task automatic model_edge();
        bit got;
        exp_ack = '0; exp_err4 = 1'b0; exp_err3 = 1'b0;
        if (age == 1) begin
            age = -1;
        end else if (age == 0) begin
            if (m_addr < 4) bank4[m_addr] = m_data; else exp_err4 = 1'b1;
            if (m_addr < 3) bank3[m_addr] = m_data; else exp_err3 = 1'b1;
            exp_ack[m_id] = 1'b1;
            m_last = m_id;
            age = 1;
        end else if (req != '0) begin
            got = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!got && req[(m_last + k) % NREQ]) begin
                    m_id = (m_last + k) % NREQ;
                    got  = 1'b1;
                end
            end
            m_addr    = int'(wr_addr[m_id*AW +: AW]);
            m_data    = wr_data[m_id*WIDTH +: WIDTH];
            exp_grant = m_id;
            age       = 0;
        end
        exp_busy = (age != -1);
    endtask

    task automatic check_all();
        chk("ack_a", 32'(ack_a), 32'(exp_ack));
        chk("ack_b", 32'(ack_b), 32'(exp_ack));
        chk("err_a", 32'(err_a), 32'(exp_err4));
        chk("err_b", 32'(err_b), 32'(exp_err3));
        chk("grant_a", 32'(gnt_a), 32'(exp_grant));
        chk("grant_b", 32'(gnt_b), 32'(exp_grant));
        chk("busy_a", 32'(busy_a), 32'(exp_busy));
        chk("busy_b", 32'(busy_b), 32'(exp_busy));
        chk("rd_a", 32'(rd_a), 32'(bank4[rd_addr]));
        chk("rd_b", 32'(rd_b), (rd_addr < 3) ? 32'(bank3[rd_addr]) : 32'h0);
    endtask

    // One clock: model the edge, check #1 later, then requesters release on their ack.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        req = req & ~exp_ack;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        req   = '0;
        model_reset();
        #1;
        chk("rst_ack", 32'(ack_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        chk("rst_grant", 32'(gnt_a), 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i);
            #1;
            chk("rst_rd_a", 32'(rd_a), 32'h0);
            chk("rst_rd_b", 32'(rd_b), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_req(input int i, input int addr, input int data);
        wr_addr[i*AW +: AW]       = AW'(addr);
        wr_data[i*WIDTH +: WIDTH] = WIDTH'(data);
        req[i]                    = 1'b1;
    endtask

    task automatic drain();
        req = '0;
        for (int g = 0; g < 6 && age != -1; g++) step();
        chk("drain_idle", 32'(age == -1), 32'h1);
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    int               ack_ids[$];
    int               ack_cyc[$];
    logic [WIDTH-1:0] snap [3];

    initial begin
        reset = 1'b0; req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Single write from requester 1
        step();
        set_req(1, 2, 'hA5);
        step();
        chk("t2_grant", 32'(gnt_a), 32'h1);
        step();
        chk("t2_ack", 32'(ack_a), 32'h2);
        step();
        chk("t2_ack_low", 32'(ack_a), 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i);
            #1;
            chk("t2_bank", 32'(rd_a), (i == 2) ? 32'hA5 : 32'h0);
        end

        // Reset mid-run clears the bank
        do_reset();

        // All four at once
        for (int i = 0; i < NREQ; i++) set_req(i, i, 'h10 + i);
        for (int c = 0; c < 12; c++) begin
            step();
            if (ack_a != '0) begin
                ack_ids.push_back(onehot_idx(ack_a));
                ack_cyc.push_back(c);
            end
        end
        chk("t3_nacks", 32'(ack_ids.size()), 32'h4);
        for (int i = 0; i < 4 && i < ack_ids.size(); i++) begin
            chk("t3_order", 32'(ack_ids[i]), 32'(i));
            if (i > 0) chk("t3_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'h3);
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i);
            #1;
            chk("t3_bank", 32'(rd_a), 32'h10 + 32'(i));
        end

        // Two persistent requesters alternate
        ack_ids.delete();
        set_req(0, 0, $urandom); set_req(2, 1, $urandom);
        for (int c = 0; c < 14; c++) begin
            step();
            if (ack_a != '0) ack_ids.push_back(onehot_idx(ack_a));
            req[0] = 1'b1; req[2] = 1'b1;
        end
        chk("t4_nacks", 32'(ack_ids.size() >= 4), 32'h1);
        for (int i = 0; i < 4 && i < ack_ids.size(); i++) begin
            chk("t4_alt", 32'(ack_ids[i]), (i % 2 == 0) ? 32'h0 : 32'h2);
        end
        drain();

        // Reset during WRITE aborts the transaction
        set_req(3, 1, 'hFF);
        step();
        chk("t5_busy", 32'(busy_a), 32'h1);
        do_reset();
        for (int c = 0; c < 6; c++) step();
        rd_addr = 2'd1;
        #1;
        chk("t5_bank1", 32'(rd_a), 32'h0);
        chk("t5_idle", 32'(busy_a), 32'h0);

        // Randomized traffic with commit-rule disturbances
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && $urandom_range(0, 3) == 0) begin
                    wr_addr[i*AW +: AW]       = AW'($urandom);
                    wr_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
                if (!req[i] && !(age >= 0 && m_id == i) && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, 3), $urandom);
            end
            if (age == 0 && $urandom_range(0, 3) == 0) req[m_id] = 1'b0;
            rd_addr = AW'($urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
        end
        drain();

        // Out-of-range address on the short bank
        for (int i = 0; i < 3; i++) snap[i] = bank3[i];
        set_req(1, 3, 'h55);
        step();
        step();
        chk("t6_ack_b", 32'(ack_b), 32'h2);
        chk("t6_err_b", 32'(err_b), 32'h1);
        chk("t6_err_a", 32'(err_a), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i);
            #1;
            chk("t6_bank_b", 32'(rd_b), (i < 3) ? 32'(snap[i]) : 32'h0);
        end
        chk("t6_bank_a3", 32'(rd_a), 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
